stateless_pre: RTL and testbench
================================

# stateless_pre

Two-stage pipelined stateless ALU stage that sits directly upstream of the predicated read-add-write stateful atom. Each packet arrives as three 32-bit header fields, and the stage produces the atom's two packet operands, `pkt_1` and `pkt_2`. `pkt_1` is a configurable ALU result over selected header fields and a constant; `pkt_2` is a selected header field passed through. `pkt_vld` marks cycles carrying a real packet, and the integration uses it as the atom's state-update enable.

## Interface
- `W`, default 32: datapath width for header fields, constant and outputs.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `hdr_a`, `hdr_b`, `hdr_c`  in  W each  packet header fields.
- `in_vld`  in  1  upstream packet valid.
- `in_rdy`  out  1  stage can accept a packet this cycle.
- `cons`  in  W  configuration constant.
- `sel_x`  in  2  ALU operand X select: 0 `hdr_a`, 1 `hdr_b`, 2 `hdr_c`, 3 `cons`.
- `sel_y`  in  2  ALU operand Y select, same encoding as `sel_x`.
- `sel_p2`  in  2  `pkt_2` select: 0 `hdr_a`, 1 `hdr_b`, 2/3 `hdr_c`.
- `alu_op`  in  3  ALU operation:
  - 0 X+Y, 1 X−Y, 2 X&Y, 3 X|Y
  - 4 X^Y, 5 X<<Y[4:0], 6 X>>Y[4:0] (logical), 7 X.
- `pkt_1`, `pkt_2`  out  W  operands to the stateful atom.
- `pkt_vld`  out  1  output packet valid.
- `pkt_rdy`  in  1  downstream accepts.
- `pkt_cnt`  out  32  count of packets accepted at the input.

## Operation
- Transfer rules:
  - Input transfer occurs when `in_vld && in_rdy`.
  - Output transfer occurs when `pkt_vld && pkt_rdy`.
- Stage 1 (S1):
  - On input transfer, registers the operands X and Y, the selected `pkt_2` source and `alu_op`.
  - All config (`cons`, `sel_*`, `alu_op`) is sampled at input transfer only. Changing config while a packet is in flight does not affect it.
- Stage 2 (S2):
  - On advance, registers `pkt_1` = ALU(X, Y) and `pkt_2` = the S1 passthrough value. `pkt_vld` = S2 valid.
- Advance conditions:
  - `s2_adv` = `s1_vld && (!s2_vld || pkt_rdy)`.
  - `in_rdy` = `!s1_vld || s2_adv`. This is combinational from `pkt_rdy`, which is intentional and gives full throughput.
- Valid bit updates:
  - S1 valid sets on input transfer; it clears when S1 advances with no new input.
  - S2 valid sets on `s2_adv`; it clears on an output transfer with no `s2_adv`.
- Stall behaviour:
  - While `pkt_vld && !pkt_rdy`, `pkt_1`, `pkt_2` and `pkt_vld` hold stable.
  - S1 holds if occupied.
  - No packet is dropped or duplicated.
- Arithmetic:
  - All W-bit modulo 2^W, unsigned. Add and subtract wrap silently.
  - Shift amount uses `Y[4:0]` only; the upper bits of Y are ignored.
- `pkt_cnt` increments by 1 per input transfer and wraps 0xFFFFFFFF→0.
- Reset (asynchronous, any time):
  - S1/S2 valid, `pkt_1`, `pkt_2`, all internal registers and `pkt_cnt` go to 0.
  - In-flight packets are discarded.
  - `in_rdy` is 1 out of reset, since S1 is empty.

## Timing
- Latency: a packet accepted at edge N appears on `pkt_1`/`pkt_2` with `pkt_vld`=1 immediately after edge N+1, given no stall.
- Throughput: 1 packet/cycle with `pkt_rdy` held high.
- Capacity: 2 packets (S1 + S2). With `pkt_rdy`=0 and both stages full, `in_rdy`=0.
- Simultaneous input transfer, S1→S2 advance and output transfer in one cycle: all three take effect; occupancy is unchanged.
- The state-update enable at the atom is `pkt_vld && pkt_rdy`, so each packet updates atom state exactly once.

## Test plan
- Reset release: after `rst` deasserts, `in_rdy`=1, `pkt_vld`=0, `pkt_1`=`pkt_2`=0, `pkt_cnt`=0.
- Add, single packet:
  - Setup: `alu_op`=0, `sel_x`=0, `sel_y`=3, `cons`=5, `sel_p2`=1, `hdr_a`=10, `hdr_b`=7, `pkt_rdy`=1.
  - Required: two cycles after acceptance, `pkt_1`=15, `pkt_2`=7, `pkt_vld` high for 1 cycle; `pkt_cnt`=1.
- Wrap and shift:
  - `alu_op`=1 with X=0, Y=1 → `pkt_1`=0xFFFFFFFF.
  - `alu_op`=5 with X=1, Y=0x21 → `pkt_1`=2.
- Backpressure:
  - Stimulus: stream packets with `hdr_a`=1,2,3,4, `alu_op`=7, and hold `pkt_rdy`=0 for 4 cycles after the first output.
  - Required: `in_rdy` drops after 2 accepted; outputs 1,2,3,4 appear in order with none lost and none repeated; `pkt_1` stays stable while stalled.
- Config change in flight: change `alu_op` from 0 to 2 the cycle after acceptance → the in-flight packet still produces the sum; the next packet produces the AND.
- Mid-operation reset: assert `rst` with both stages full → `pkt_vld` drops to 0 immediately (asynchronously); after release, no stale packet emerges and `pkt_cnt`=0.

Source files
------------

// File: rtl/stateless_pre.sv
// Two-stage stateless ALU stage feeding the predicated read-add-write atom.
// S1 captures selected operands and op; S2 holds the ALU result and passthrough.
module stateless_pre #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] hdr_a,
  input  logic [W-1:0] hdr_b,
  input  logic [W-1:0] hdr_c,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] cons,
  input  logic [1:0]   sel_x,
  input  logic [1:0]   sel_y,
  input  logic [1:0]   sel_p2,
  input  logic [2:0]   alu_op,
  output logic [W-1:0] pkt_1,
  output logic [W-1:0] pkt_2,
  output logic         pkt_vld,
  input  logic         pkt_rdy,
  output logic [31:0]  pkt_cnt
);

  logic         s1_vld_r;
  logic [W-1:0] s1_x_r;
  logic [W-1:0] s1_y_r;
  logic [W-1:0] s1_p2_r;
  logic [2:0]   s1_op_r;
  logic         s2_vld_r;
  logic [W-1:0] pkt_1_r;
  logic [W-1:0] pkt_2_r;
  logic [31:0]  pkt_cnt_r;

  logic         in_xfer_s;
  logic         out_xfer_s;
  logic         s2_adv_s;
  logic         in_rdy_s;
  logic [W-1:0] x_s;
  logic [W-1:0] y_s;
  logic [W-1:0] p2_s;
  logic [W-1:0] alu_s;

  function automatic logic [W-1:0] operand_sel(
    input logic [1:0]   sel,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [W-1:0] c,
    input logic [W-1:0] k
  );
    case (sel)
      2'd0:    operand_sel = a;
      2'd1:    operand_sel = b;
      2'd2:    operand_sel = c;
      default: operand_sel = k;
    endcase
  endfunction

  // Shift amount deliberately limited to Y[4:0]; everything wraps modulo 2^W.
  function automatic logic [W-1:0] alu(
    input logic [2:0]   op,
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    case (op)
      3'd0:    alu = x + y;
      3'd1:    alu = x - y;
      3'd2:    alu = x & y;
      3'd3:    alu = x | y;
      3'd4:    alu = x ^ y;
      3'd5:    alu = x << y[4:0];
      3'd6:    alu = x >> y[4:0];
      default: alu = x;
    endcase
  endfunction

  // Handshake, advance and operand selection.
  always_comb begin
    s2_adv_s   = 1'b0;
    in_rdy_s   = 1'b0;
    in_xfer_s  = 1'b0;
    out_xfer_s = 1'b0;
    x_s        = operand_sel(sel_x, hdr_a, hdr_b, hdr_c, cons);
    y_s        = operand_sel(sel_y, hdr_a, hdr_b, hdr_c, cons);
    alu_s      = alu(s1_op_r, s1_x_r, s1_y_r);
    if (sel_p2 == 2'd0) begin
      p2_s = hdr_a;
    end else if (sel_p2 == 2'd1) begin
      p2_s = hdr_b;
    end else begin
      p2_s = hdr_c;
    end
    s2_adv_s   = s1_vld_r && (!s2_vld_r || pkt_rdy);
    in_rdy_s   = !s1_vld_r || s2_adv_s;
    in_xfer_s  = in_vld && in_rdy_s;
    out_xfer_s = s2_vld_r && pkt_rdy;
  end

  // Stage 1: config is captured with the packet, so later changes do not affect it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_r <= 1'b0;
      s1_x_r   <= {W{1'b0}};
      s1_y_r   <= {W{1'b0}};
      s1_p2_r  <= {W{1'b0}};
      s1_op_r  <= 3'd0;
    end else begin
      if (in_xfer_s) begin
        s1_vld_r <= 1'b1;
        s1_x_r   <= x_s;
        s1_y_r   <= y_s;
        s1_p2_r  <= p2_s;
        s1_op_r  <= alu_op;
      end else if (s2_adv_s) begin
        s1_vld_r <= 1'b0;
      end
    end
  end

  // Stage 2: holds result stable while the atom stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_r <= 1'b0;
      pkt_1_r  <= {W{1'b0}};
      pkt_2_r  <= {W{1'b0}};
    end else begin
      if (s2_adv_s) begin
        s2_vld_r <= 1'b1;
        pkt_1_r  <= alu_s;
        pkt_2_r  <= s1_p2_r;
      end else if (out_xfer_s) begin
        s2_vld_r <= 1'b0;
      end
    end
  end

  // Accepted-packet counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_r <= 32'd0;
    end else if (in_xfer_s) begin
      pkt_cnt_r <= pkt_cnt_r + 32'd1;
    end
  end

  assign in_rdy  = in_rdy_s;
  assign pkt_1   = pkt_1_r;
  assign pkt_2   = pkt_2_r;
  assign pkt_vld = s2_vld_r;
  assign pkt_cnt = pkt_cnt_r;

endmodule

// File: tb/tb_stateless_pre.sv
// Directed, table-driven bench for stateless_pre with hand-written stall,
// config-change and reset sequences.
module tb_stateless_pre;

  logic        clk;
  logic        rst;
  logic [31:0] hdr_a, hdr_b, hdr_c, cons;
  logic        in_vld, in_rdy;
  logic [1:0]  sel_x, sel_y, sel_p2;
  logic [2:0]  alu_op;
  logic [31:0] pkt_1, pkt_2, pkt_cnt;
  logic        pkt_vld, pkt_rdy;

  int checks = 0;
  int errors = 0;

  stateless_pre #(.W(32)) dut (
    .clk(clk), .rst(rst),
    .hdr_a(hdr_a), .hdr_b(hdr_b), .hdr_c(hdr_c),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .cons(cons), .sel_x(sel_x), .sel_y(sel_y), .sel_p2(sel_p2), .alu_op(alu_op),
    .pkt_1(pkt_1), .pkt_2(pkt_2), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy),
    .pkt_cnt(pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  sx, sy, sp;
    logic [31:0] a, b, c, k;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt_model;
    int accepted, emitted, occ, stall_left, bound;
    bit first_seen, prev_stall, saw_block;
    logic [31:0] prev_p1;
    logic [31:0] bp_vals[4];

    //      op    sx    sy    sp    a             b             c             k             e1            e2
    vecs[0] = '{3'd0, 2'd0, 2'd3, 2'd1, 32'd10,       32'd7,        32'd0,        32'd5,        32'd15,       32'd7};
    vecs[1] = '{3'd1, 2'd0, 2'd1, 2'd2, 32'd0,        32'd1,        32'd3,        32'd0,        32'hFFFFFFFF, 32'd3};
    vecs[2] = '{3'd5, 2'd0, 2'd1, 2'd3, 32'd1,        32'h21,       32'd9,        32'd0,        32'd2,        32'd9};
    vecs[3] = '{3'd6, 2'd3, 2'd0, 2'd0, 32'd4,        32'd0,        32'd0,        32'h80000000, 32'h08000000, 32'd4};
    vecs[4] = '{3'd2, 2'd1, 2'd2, 2'd1, 32'd0,        32'h0000F0F0, 32'h0000FF00, 32'd0,        32'h0000F000, 32'h0000F0F0};
    vecs[5] = '{3'd3, 2'd0, 2'd1, 2'd0, 32'h0F,       32'hF0,       32'd0,        32'd0,        32'hFF,       32'h0F};
    vecs[6] = '{3'd4, 2'd0, 2'd2, 2'd2, 32'hFF,       32'd0,        32'h0F,       32'd0,        32'hF0,       32'h0F};
    vecs[7] = '{3'd7, 2'd2, 2'd0, 2'd1, 32'd0,        32'h55,       32'h1234,     32'd0,        32'h1234,     32'h55};
    vecs[8] = '{3'd0, 2'd3, 2'd3, 2'd0, 32'd0,        32'd0,        32'd0,        32'h80000001, 32'd2,        32'd0};

    rst = 1'b1; in_vld = 1'b0; pkt_rdy = 1'b1;
    hdr_a = 32'd0; hdr_b = 32'd0; hdr_c = 32'd0; cons = 32'd0;
    sel_x = 2'd0; sel_y = 2'd0; sel_p2 = 2'd0; alu_op = 3'd0;
    #22 rst = 1'b0;
    tick();
    chk("reset_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("reset_pkt_vld", {31'd0, pkt_vld}, 32'd0);
    chk("reset_pkt_1", pkt_1, 32'd0);
    chk("reset_pkt_2", pkt_2, 32'd0);
    chk("reset_pkt_cnt", pkt_cnt, 32'd0);
    cnt_model = 0;

    // Single packets through the table, one at a time.
    for (int i = 0; i < 9; i++) begin
      alu_op = vecs[i].op; sel_x = vecs[i].sx; sel_y = vecs[i].sy; sel_p2 = vecs[i].sp;
      hdr_a = vecs[i].a; hdr_b = vecs[i].b; hdr_c = vecs[i].c; cons = vecs[i].k;
      in_vld = 1'b1;
      tick();
      in_vld = 1'b0;
      cnt_model++;
      chk($sformatf("vec%0d_early_vld", i), {31'd0, pkt_vld}, 32'd0);
      tick();
      chk($sformatf("vec%0d_vld", i), {31'd0, pkt_vld}, 32'd1);
      chk($sformatf("vec%0d_pkt_1", i), pkt_1, vecs[i].e1);
      chk($sformatf("vec%0d_pkt_2", i), pkt_2, vecs[i].e2);
      chk($sformatf("vec%0d_cnt", i), pkt_cnt, cnt_model);
      tick();
      chk($sformatf("vec%0d_vld_drop", i), {31'd0, pkt_vld}, 32'd0);
    end

    // Backpressure: pass-through of hdr_a with a 4-cycle stall after first output.
    bp_vals[0] = 32'd1; bp_vals[1] = 32'd2; bp_vals[2] = 32'd3; bp_vals[3] = 32'd4;
    alu_op = 3'd7; sel_x = 2'd0; sel_y = 2'd0; sel_p2 = 2'd0;
    accepted = 0; emitted = 0; stall_left = 0;
    first_seen = 1'b0; prev_stall = 1'b0; saw_block = 1'b0; prev_p1 = 32'd0;
    bound = 0;
    while (emitted < 4 && bound < 40) begin
      if (pkt_vld && !first_seen) begin
        first_seen = 1'b1;
        stall_left = 4;
      end
      pkt_rdy = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      in_vld = (accepted < 4);
      hdr_a  = (accepted < 4) ? bp_vals[accepted] : 32'd0;
      #1;
      occ = accepted - emitted;
      chk("bp_in_rdy", {31'd0, in_rdy}, {31'd0, (occ < 2) || pkt_rdy});
      if (!in_rdy) saw_block = 1'b1;
      if (prev_stall) begin
        chk("bp_stall_vld", {31'd0, pkt_vld}, 32'd1);
        chk("bp_stall_stable", pkt_1, prev_p1);
      end
      if (pkt_vld && pkt_rdy) begin
        chk("bp_order", pkt_1, bp_vals[emitted]);
        emitted++;
      end
      prev_stall = pkt_vld && !pkt_rdy;
      prev_p1 = pkt_1;
      if (in_vld && in_rdy) accepted++;
      bound++;
      tick();
    end
    in_vld = 1'b0;
    pkt_rdy = 1'b1;
    chk("bp_all_out", emitted, 32'd4);
    chk("bp_saw_block", {31'd0, saw_block}, 32'd1);
    cnt_model += accepted;
    for (int i = 0; i < 3; i++) begin
      chk("bp_no_dup", {31'd0, pkt_vld}, 32'd0);
      tick();
    end
    chk("bp_cnt", pkt_cnt, cnt_model);

    // Config change while a packet is in flight.
    alu_op = 3'd0; sel_x = 2'd0; sel_y = 2'd1; sel_p2 = 2'd0;
    hdr_a = 32'd3; hdr_b = 32'd6; in_vld = 1'b1;
    tick();
    alu_op = 3'd2; hdr_a = 32'hC; hdr_b = 32'hA;
    tick();
    in_vld = 1'b0;
    cnt_model += 2;
    chk("cfg_first_vld", {31'd0, pkt_vld}, 32'd1);
    chk("cfg_first_sum", pkt_1, 32'd9);
    chk("cfg_first_p2", pkt_2, 32'd3);
    tick();
    chk("cfg_second_vld", {31'd0, pkt_vld}, 32'd1);
    chk("cfg_second_and", pkt_1, 32'd8);
    chk("cfg_cnt", pkt_cnt, cnt_model);
    tick();

    // Asynchronous reset with both stages full.
    pkt_rdy = 1'b0; alu_op = 3'd7; hdr_a = 32'hAA; in_vld = 1'b1;
    tick();
    hdr_a = 32'hBB;
    tick();
    in_vld = 1'b0;
    chk("full_vld", {31'd0, pkt_vld}, 32'd1);
    chk("full_in_rdy", {31'd0, in_rdy}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", {31'd0, pkt_vld}, 32'd0);
    chk("arst_pkt_1", pkt_1, 32'd0);
    chk("arst_cnt", pkt_cnt, 32'd0);
    #10 rst = 1'b0;
    pkt_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_no_stale", {31'd0, pkt_vld}, 32'd0);
    end
    chk("arst_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("arst_cnt_after", pkt_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
